// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, PC source select and fetch FSM states.
// Also holds the PC step used by the fetch front end.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    PC_SEQ,
    PC_BR,
    PC_J,
    PC_JR
  } pcsrc_t;

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    MEM,
    HALTED
  } fetch_state_t;

  localparam word_t PC_STEP = 32'd4;

  function automatic word_t sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection for the fetch front end.
// Jump targets keep the top nibble of pc+4; JR clears misaligned bits.
module pc_next_logic
  import cpu_types_pkg::*;
(
  input  logic [31:0] pc,
  input  pcsrc_t      pc_src,
  input  logic [15:0] imm16,
  input  logic [25:0] jaddr,
  input  logic [31:0] rs_data,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  assign pc_plus4 = pc + PC_STEP;

  // select the target for the retiring instruction
  always_comb begin
    next_pc = pc_plus4;
    unique case (pc_src)
      PC_SEQ: next_pc = pc_plus4;
      PC_BR:  next_pc = pc_plus4 + (sext16(imm16) << 2);
      PC_J:   next_pc = {pc_plus4[31:28], jaddr, 2'b00};
      PC_JR:  next_pc = {rs_data[31:2], 2'b00};
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_request_unit.sv
// Fetch front end: owns PC and instruction register, sequences
// icache/dcache requests and emits the one-cycle commit strobe.
module fetch_request_unit
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
)
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  pc_src,
  input  logic [15:0] imm16,
  input  logic [25:0] jaddr,
  input  logic [31:0] rs_data,
  input  logic        halt_in,
  input  logic        dREN_in,
  input  logic        dWEN_in,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        dhit,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        commit,
  output logic        halt
);

  fetch_state_t state;
  fetch_state_t state_nx;
  logic [31:0]  next_pc;
  logic         mem_req;

  assign mem_req  = dREN_in | dWEN_in;
  assign imemaddr = pc;

  pc_next_logic u_pc_next (
    .pc       (pc),
    .pc_src   (pcsrc_t'(pc_src)),
    .imm16    (imm16),
    .jaddr    (jaddr),
    .rs_data  (rs_data),
    .pc_plus4 (pc_plus4),
    .next_pc  (next_pc)
  );

  // state register
  always_ff @(posedge CLK) begin
    if (RST) state <= FETCH;
    else     state <= state_nx;
  end

  // PC advances on commit; instr latches on an in-FETCH hit
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc    <= PC_INIT;
      instr <= '0;
    end else begin
      if (state == FETCH && ihit) instr <= imemload;
      if (commit)                 pc    <= next_pc;
    end
  end

  // next-state: halt beats memory, memory beats retire
  always_comb begin
    state_nx = state;
    unique case (state)
      FETCH: if (ihit) state_nx = EXEC;
      EXEC: begin
        if (halt_in)      state_nx = HALTED;
        else if (mem_req) state_nx = MEM;
        else              state_nx = FETCH;
      end
      MEM:    if (dhit) state_nx = FETCH;
      HALTED: state_nx = HALTED;
      default: state_nx = FETCH;
    endcase
  end

  // per-state enables and commit strobe; a write wins over a read
  always_comb begin
    imemREN = 1'b0;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    commit  = 1'b0;
    halt    = 1'b0;
    unique case (state)
      FETCH: imemREN = 1'b1;
      EXEC:  commit  = ~halt_in & ~mem_req;
      MEM: begin
        dmemWEN = dWEN_in;
        dmemREN = dREN_in & ~dWEN_in;
        commit  = dhit;
      end
      HALTED: halt = 1'b1;
      default: ;
    endcase
  end

endmodule
